// File: rtl/loopback_pkg.sv
// loopback_pkg: shared encodings and helpers for the loopback pattern
// generator / checker (pattern modes, FSM states, PRBS-7 seed and step).
package loopback_pkg;

    // Pattern select encodings on the mode input.
    typedef enum logic [1:0] {
        MODE_WALK = 2'd0,
        MODE_CNT  = 2'd1,
        MODE_PRBS = 2'd2,
        MODE_CHK  = 2'd3
    } mode_e;

    // Burst sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [6:0]  PRBS7_SEED  = 7'h7F;
    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    // Feedback bit of the x^7 + x^6 + 1 LFSR (Fibonacci form).
    function automatic logic prbs7_fb(input logic [6:0] lfsr);
        return lfsr[6] ^ lfsr[5];
    endfunction

    // Saturating increment for the 16-bit error counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == ERR_CNT_MAX) begin
            r = ERR_CNT_MAX;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/loopback_dly_line.sv
// loopback_dly_line: W-bit shift register of DEPTH registered stages with a
// selectable tap. Tap 0 is the undelayed input, tap n is the input n clocks ago.
// A tap above DEPTH reads as all zeros.
module loopback_dly_line
    import loopback_pkg::*;
#(
    parameter int  W     = 29,
    parameter int  DEPTH = 15,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic [W-1:0]     din,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     dout
);

    logic [W-1:0] stage_r [1:DEPTH];

    // Shift one stage per clock; clr empties the line so stale words never reach the tap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= DEPTH; i++) begin
                stage_r[i] <= {W{1'b0}};
            end
        end else if (clr) begin
            for (int i = 1; i <= DEPTH; i++) begin
                stage_r[i] <= {W{1'b0}};
            end
        end else begin
            stage_r[1] <= din;
            for (int i = 2; i <= DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    // Tap select mux.
    always_comb begin
        dout = {W{1'b0}};
        if (sel == {SEL_W{1'b0}}) begin
            dout = din;
        end else begin
            for (int i = 1; i <= DEPTH; i++) begin
                dout = (sel == SEL_W'(i)) ? stage_r[i] : dout;
            end
        end
    end

endmodule

// File: rtl/loopback_stim_chk.sv
// loopback_stim_chk: drives a WIDTH-bit test pattern for a programmable burst
// and checks the returned bus against a delay-aligned copy of what was sent.
// Optional feature macro: LOOPBACK_PRBS_EN -- builds the PRBS-7 source for
// mode 2; when undefined, mode 2 produces the walking-one pattern.
module loopback_stim_chk
    import loopback_pkg::*;
#(
    parameter int  WIDTH   = 28,
    parameter int  MAX_DLY = 15,
    parameter int  LEN_W   = 16,
    localparam int DLY_W   = $clog2(MAX_DLY + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [DLY_W-1:0] dly,
    input  logic [WIDTH-1:0] rx,
    output logic [WIDTH-1:0] tx,
    output logic             tx_en,
    output logic             busy,
    output logic             done,
    output logic [15:0]      err_cnt,
    output logic [WIDTH-1:0] err_mask
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] ZERO_L = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] ONE_L  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e           state_r, state_nx_s;
    logic [LEN_W-1:0] cnt_r, cnt_nx_s;
    logic             load_s, emit_s;

    // The pattern seed (mode 3) is captured directly into gen_r, so only
    // mode, length and delay need their own latches.
    mode_e            mode_r;
    logic [LEN_W-1:0] len_r;
    logic [DLY_W-1:0] dly_r;

    logic [WIDTH-1:0] gen_r, gen_nx_s;
    logic [WIDTH-1:0] tx_r;
    logic             tx_en_r, busy_r, done_r;
    logic [15:0]      err_cnt_r;
    logic [WIDTH-1:0] err_mask_r;

    logic [WIDTH:0]   dl_dout_s;
    logic             chk_en_s;
    logic [WIDTH-1:0] chk_data_s;

`ifdef LOOPBACK_PRBS_EN
    logic [6:0]       lfsr_r;
`endif

    // First word of a burst for each pattern mode.
    function automatic logic [WIDTH-1:0] seed_word(input mode_e m, input logic [WIDTH-1:0] pat);
        logic [WIDTH-1:0] w;
        case (m)
            MODE_WALK: w = ONE_W;
            MODE_CNT:  w = ZERO_W;
`ifdef LOOPBACK_PRBS_EN
            MODE_PRBS: w = {WIDTH{1'b1}};
`else
            MODE_PRBS: w = ONE_W;
`endif
            MODE_CHK:  w = pat;
            default:   w = ONE_W;
        endcase
        return w;
    endfunction

    // FSM state and word/drain counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= ZERO_L;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state logic: RUN emits burst_len words, DRAIN waits dly+1 clocks.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        load_s     = 1'b0;
        emit_s     = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    load_s     = 1'b1;
                    cnt_nx_s   = ZERO_L;
                    state_nx_s = (burst_len == ZERO_L) ? DRAIN : RUN;
                end else begin
                    state_nx_s = state_r;
                end
            end
            RUN: begin
                emit_s = 1'b1;
                if (cnt_r == (len_r - ONE_L)) begin
                    state_nx_s = DRAIN;
                    cnt_nx_s   = ZERO_L;
                end else begin
                    cnt_nx_s = cnt_r + ONE_L;
                end
            end
            DRAIN: begin
                if (cnt_r == LEN_W'(dly_r)) begin
                    state_nx_s = DONE;
                    cnt_nx_s   = ZERO_L;
                end else begin
                    cnt_nx_s = cnt_r + ONE_L;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = ZERO_L;
            end
        endcase
    end

    // Latch the burst configuration when a start is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_r <= MODE_WALK;
            len_r  <= ZERO_L;
            dly_r  <= {DLY_W{1'b0}};
        end else if (load_s) begin
            mode_r <= mode_e'(mode);
            len_r  <= burst_len;
            dly_r  <= dly;
        end else begin
            mode_r <= mode_r;
            len_r  <= len_r;
            dly_r  <= dly_r;
        end
    end

    // Pattern word that follows the one currently held in the generator.
    always_comb begin
        gen_nx_s = gen_r;
        case (mode_r)
            MODE_WALK: gen_nx_s = {gen_r[WIDTH-2:0], gen_r[WIDTH-1]};
            MODE_CNT:  gen_nx_s = gen_r + ONE_W;
`ifdef LOOPBACK_PRBS_EN
            MODE_PRBS: gen_nx_s = {gen_r[WIDTH-2:0], prbs7_fb(lfsr_r)};
`else
            MODE_PRBS: gen_nx_s = {gen_r[WIDTH-2:0], gen_r[WIDTH-1]};
`endif
            MODE_CHK:  gen_nx_s = ~gen_r;
            default:   gen_nx_s = gen_r;
        endcase
    end

`ifdef LOOPBACK_PRBS_EN
    // PRBS-7 state: seeded on start, one step per emitted word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_r <= PRBS7_SEED;
        end else if (load_s) begin
            lfsr_r <= PRBS7_SEED;
        end else if (emit_s) begin
            lfsr_r <= {lfsr_r[5:0], prbs7_fb(lfsr_r)};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`endif

    // Pattern generator and registered tx bus; tx idles at zero between words.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gen_r   <= ZERO_W;
            tx_r    <= ZERO_W;
            tx_en_r <= 1'b0;
        end else if (load_s) begin
            gen_r   <= seed_word(mode_e'(mode), pattern);
            tx_r    <= ZERO_W;
            tx_en_r <= 1'b0;
        end else if (emit_s) begin
            gen_r   <= gen_nx_s;
            tx_r    <= gen_r;
            tx_en_r <= 1'b1;
        end else begin
            gen_r   <= gen_r;
            tx_r    <= ZERO_W;
            tx_en_r <= 1'b0;
        end
    end

    // Status flags trail the state by one clock so busy rises with the first tx_en;
    // done drops as soon as a new start is taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_r == RUN) || (state_r == DRAIN);
            done_r <= (state_r == DONE) && !start;
        end
    end

    // Delay-aligned copy of {tx_en, tx} for the checker.
    loopback_dly_line #(
        .W     (WIDTH + 1),
        .DEPTH (MAX_DLY)
    ) u_dly_line (
        .clock (clock),
        .reset (reset),
        .clr   (load_s),
        .din   ({tx_en_r, tx_r}),
        .sel   (dly_r),
        .dout  (dl_dout_s)
    );

    assign chk_en_s   = dl_dout_s[WIDTH];
    assign chk_data_s = dl_dout_s[WIDTH-1:0];

    // Error accumulation: count mismatched words and collect failing bit positions.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_cnt_r  <= 16'h0000;
            err_mask_r <= ZERO_W;
        end else if (load_s) begin
            err_cnt_r  <= 16'h0000;
            err_mask_r <= ZERO_W;
        end else if (chk_en_s && (rx != chk_data_s)) begin
            err_cnt_r  <= sat_inc16(err_cnt_r);
            err_mask_r <= err_mask_r | (rx ^ chk_data_s);
        end else begin
            err_cnt_r  <= err_cnt_r;
            err_mask_r <= err_mask_r;
        end
    end

    assign tx       = tx_r;
    assign tx_en    = tx_en_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err_cnt  = err_cnt_r;
    assign err_mask = err_mask_r;

endmodule

// File: tb/tb_loopback_stim_chk.sv
// tb_loopback_stim_chk: table-driven and randomized bench for loopback_stim_chk.
// A channel model returns tx after a programmable delay with optional
// corruption; expected words and error totals come from a word-list model.
module tb_loopback_stim_chk;

    localparam int WIDTH   = 8;
    localparam int MAX_DLY = 15;
    localparam int LEN_W   = 17;
    localparam int DLY_W   = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] burst_len;
    logic [DLY_W-1:0] dly;
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] tx;
    logic             tx_en;
    logic             busy;
    logic             done;
    logic [15:0]      err_cnt;
    logic [WIDTH-1:0] err_mask;

    int n_chk = 0;
    int n_err = 0;

    // channel configuration
    int         ch_dly = 0;
    logic [7:0] ch_am = 8'hFF, ch_om = 8'h00, ch_xm = 8'h00, ch_ky = 8'h00, ch_km = 8'h00;
    logic [7:0] hist [0:15] = '{default: 8'h00};

    // model results
    logic [7:0] exp_q[$];
    logic [15:0] m_cnt;
    logic [7:0]  m_mask;

    typedef struct {
        string      name;
        int         m;
        logic [7:0] pat;
        int         len;
        int         d;
        logic [7:0] am, om, xm, ky, km;
        int         poke;
        logic [15:0] ecnt;
        logic [7:0]  emask;
    } vec_t;

    vec_t tbl [7];

    loopback_stim_chk #(
        .WIDTH   (WIDTH),
        .MAX_DLY (MAX_DLY),
        .LEN_W   (LEN_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .pattern   (pattern),
        .burst_len (burst_len),
        .dly       (dly),
        .rx        (rx),
        .tx        (tx),
        .tx_en     (tx_en),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .err_mask  (err_mask)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] corrupt(input logic [7:0] w, input logic [7:0] am,
                                           input logic [7:0] om, input logic [7:0] xm,
                                           input logic [7:0] ky, input logic [7:0] km);
        logic [7:0] r;
        r = (w & am) | om;
        if (((w ^ ky) & km) == 8'h00) r = r ^ xm;
        return r;
    endfunction

    // channel history: hist[j] holds tx from j+1 clocks ago
    always @(posedge clock) begin
        hist[0] <= tx;
        for (int j = 1; j < 16; j++) hist[j] <= hist[j-1];
    end

    always_comb begin
        logic [7:0] w;
        if (ch_dly == 0) w = tx;
        else             w = hist[ch_dly-1];
        rx = corrupt(w, ch_am, ch_om, ch_xm, ch_ky, ch_km);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected word list and error totals, straight from the pattern rules.
    task automatic build_model(input int m, input logic [7:0] pat, input int len);
        logic [7:0] w;
        logic [7:0] r;
        logic [6:0] lf;
        logic       fb;
        int         cnt;
        exp_q.delete();
        w = 8'h00;
        lf = 7'h7F;
        for (int i = 0; i < len; i++) begin
            case (m)
                0: w = 8'(1 << (i % 8));
                1: w = 8'(i % 256);
                2: begin
`ifdef LOOPBACK_PRBS_EN
                    if (i == 0) begin
                        w = 8'hFF;
                        lf = 7'h7F;
                    end else begin
                        fb = lf[6] ^ lf[5];
                        lf = {lf[5:0], fb};
                        w = {w[6:0], fb};
                    end
`else
                    w = 8'(1 << (i % 8));
`endif
                end
                default: w = ((i % 2) == 0) ? pat : ~pat;
            endcase
            exp_q.push_back(w);
        end
        cnt = 0;
        m_mask = 8'h00;
        foreach (exp_q[i]) begin
            r = corrupt(exp_q[i], ch_am, ch_om, ch_xm, ch_ky, ch_km);
            if (r != exp_q[i]) begin
                cnt++;
                m_mask = m_mask | (r ^ exp_q[i]);
            end
        end
        m_cnt = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
    endtask

    task automatic run_burst(input string name, input int m, input logic [7:0] pat,
                             input int len, input int d,
                             input logic [7:0] am, input logic [7:0] om, input logic [7:0] xm,
                             input logic [7:0] ky, input logic [7:0] km,
                             input bit use_tbl, input logic [15:0] t_cnt, input logic [7:0] t_mask,
                             input bit cyc_chk, input int poke);
        int c;
        int tgt;
        int budget;
        logic [15:0] e_cnt;
        logic [7:0]  e_mask;
        ch_dly = d; ch_am = am; ch_om = om; ch_xm = xm; ch_ky = ky; ch_km = km;
        build_model(m, pat, len);
        e_cnt  = use_tbl ? t_cnt : m_cnt;
        e_mask = use_tbl ? t_mask : m_mask;
        mode = 2'(m); pattern = pat; burst_len = 17'(len); dly = 4'(d);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        tgt = len + d + 2;
        budget = tgt + 10;
        c = 0;
        while (c < budget && done !== 1'b1) begin
            if (cyc_chk) begin
                chk({name, ".tx_en"}, tx_en, (c >= 1 && c <= len));
                if (c >= 1 && c <= len) chk({name, ".tx"}, tx, exp_q[c-1]);
                chk({name, ".busy"}, busy, (c >= 1 && c < tgt));
            end
            if (c == poke) begin
                start = 1'b1; mode = 2'd3; burst_len = 17'd3; dly = 4'd0; pattern = 8'h0F;
            end
            @(posedge clock); #1;
            start = 1'b0;
            c++;
        end
        chk({name, ".done_latency"}, c, tgt);
        chk({name, ".busy_at_done"}, busy, 1'b0);
        chk({name, ".err_cnt"}, err_cnt, e_cnt);
        chk({name, ".err_mask"}, err_mask, e_mask);
        repeat (2) begin
            @(posedge clock); #1;
        end
        chk({name, ".done_hold"}, done, 1'b1);
        chk({name, ".err_cnt_hold"}, err_cnt, e_cnt);
        chk({name, ".err_mask_hold"}, err_mask, e_mask);
    endtask

    initial begin
        tbl[0] = '{"walk",        0, 8'h00,  10,  3, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, -1, 16'd0,   8'h00};
        tbl[1] = '{"cnt_wrap",    1, 8'h00, 300,  0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, -1, 16'd0,   8'h00};
        tbl[2] = '{"chk_stuck",   3, 8'hA5,  10,  2, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, -1, 16'd5,   8'h10};
        tbl[3] = '{"mode2_inv",   2, 8'h00, 127,  5, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, -1, 16'd127, 8'hFF};
        tbl[4] = '{"len0_maxdly", 0, 8'h00,   0, 15, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, -1, 16'd0,   8'h00};
        tbl[5] = '{"chk_or",      3, 8'h3C,   7, 15, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, -1, 16'd4,   8'h01};
        tbl[6] = '{"start_ign",   1, 8'h00,  20,  1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,  5, 16'd0,   8'h00};

        reset = 1'b1; start = 1'b0; mode = 2'd0; pattern = 8'h00; burst_len = 17'd0; dly = 4'd0;
        #2;
        chk("rst.tx", tx, 8'h00);
        chk("rst.tx_en", tx_en, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.err_cnt", err_cnt, 16'h0000);
        chk("rst.err_mask", err_mask, 8'h00);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        chk("idle.done", done, 1'b0);
        chk("idle.tx_en", tx_en, 1'b0);

        for (int i = 0; i < 7; i++) begin
            run_burst(tbl[i].name, tbl[i].m, tbl[i].pat, tbl[i].len, tbl[i].d,
                      tbl[i].am, tbl[i].om, tbl[i].xm, tbl[i].ky, tbl[i].km,
                      1'b1, tbl[i].ecnt, tbl[i].emask, 1'b1, tbl[i].poke);
        end

        // reset in the middle of an all-bad burst, then a clean burst
        ch_dly = 2; ch_am = 8'hFF; ch_om = 8'h00; ch_xm = 8'hFF; ch_ky = 8'h00; ch_km = 8'h00;
        mode = 2'd1; pattern = 8'h00; burst_len = 17'd50; dly = 4'd2;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
        end
        chk("midrst.err_before", err_cnt, 16'd17);
        #2 reset = 1'b1;
        #1;
        chk("midrst.tx", tx, 8'h00);
        chk("midrst.tx_en", tx_en, 1'b0);
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.done", done, 1'b0);
        chk("midrst.err_cnt", err_cnt, 16'h0000);
        chk("midrst.err_mask", err_mask, 8'h00);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        run_burst("after_rst", 1, 8'h00, 20, 2, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
                  1'b1, 16'd0, 8'h00, 1'b1, -1);

        // randomized bursts against the model
        for (int k = 0; k < 14; k++) begin
            int         rm, rl, rd;
            logic [7:0] rp, ram, rom, rxm, rky, rkm;
            rm  = $urandom_range(0, 3);
            rp  = 8'($urandom);
            rl  = $urandom_range(0, 40);
            rd  = $urandom_range(0, 15);
            ram = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            rom = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            rxm = 8'($urandom);
            rky = 8'($urandom);
            rkm = 8'($urandom_range(0, 3));
            run_burst($sformatf("rnd%0d", k), rm, rp, rl, rd, ram, rom, rxm, rky, rkm,
                      1'b0, 16'd0, 8'h00, 1'b1, -1);
        end

        // counter saturation: more than 65535 bad words in one burst
        run_burst("sat", 1, 8'h00, 65600, 0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00,
                  1'b1, 16'hFFFF, 8'hFF, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
